// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: opcodes, FSM states, error codes and instruction layout.
// Defining ALU_SEQ_CALLSTACK_EN makes the call/return opcodes legal.
package alu_pkg;

  localparam int OPC_W    = 8;
  localparam int RD_W     = 4;
  localparam int RS_W     = 4;
  localparam int IMM_W    = 16;
  localparam int INSTR_W  = OPC_W + RD_W + RS_W + IMM_W;
  localparam int NUM_REGS = 2 ** RD_W;

  localparam logic [OPC_W-1:0] OP_ILLEGAL     = 8'd0;
  localparam logic [OPC_W-1:0] OP_SHIFT_FIRST = 8'd19;
  localparam logic [OPC_W-1:0] OP_SHIFT_LAST  = 8'd28;
  localparam logic [OPC_W-1:0] OP_WB_LAST     = 8'd31;
  localparam logic [OPC_W-1:0] OP_JUD         = 8'd32;
  localparam logic [OPC_W-1:0] OP_JUP         = 8'd33;
  localparam logic [OPC_W-1:0] OP_JCD         = 8'd34;
  localparam logic [OPC_W-1:0] OP_JCP         = 8'd35;
  localparam logic [OPC_W-1:0] OP_CUD         = 8'd36;
  localparam logic [OPC_W-1:0] OP_CUP         = 8'd37;
  localparam logic [OPC_W-1:0] OP_CCD         = 8'd38;
  localparam logic [OPC_W-1:0] OP_CCP         = 8'd39;
  localparam logic [OPC_W-1:0] OP_RTU         = 8'd40;
  localparam logic [OPC_W-1:0] OP_RTC         = 8'd41;
  localparam logic [OPC_W-1:0] OP_MVR         = 8'd47;
  localparam logic [OPC_W-1:0] OP_NOP         = 8'd53;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_ILLEGAL   = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_UNDERFLOW = 2'd3
  } err_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [RD_W-1:0]  rd;
    logic [RS_W-1:0]  rs;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    logic ok;
    ok = (op != OP_ILLEGAL) && (op <= OP_NOP);
`ifndef ALU_SEQ_CALLSTACK_EN
    if (op >= OP_CUD && op <= OP_RTC) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic op_is_shift(input logic [OPC_W-1:0] op);
    return (op >= OP_SHIFT_FIRST) && (op <= OP_SHIFT_LAST);
  endfunction

  function automatic logic op_writes_rd(input logic [OPC_W-1:0] op);
    return ((op != OP_ILLEGAL) && (op <= OP_WB_LAST)) || (op == OP_MVR);
  endfunction

endpackage

// File: rtl/alu_seq_rstack.sv
// Return-address stack for alu_seq: RS_DEPTH entries of PC_W bits, LIFO.
// Callers must not push when full or pop when empty; such requests are ignored.
module alu_seq_rstack #(
  parameter int PC_W     = 8,
  parameter int RS_DEPTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int SP_W  = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [PC_W-1:0] mem_q [RS_DEPTH];
  logic [SP_W-1:0] sp_q;

  assign full_o  = (sp_q == SP_W'(RS_DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[IDX_W'(sp_q - SP_W'(1))];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_i && !full_o) mem_q[IDX_W'(sp_q)] <= data_i;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencer driving an external ALU: fetch, decode, execute, write back, with jumps and calls.
// Define ALU_SEQ_CALLSTACK_EN to build the return stack; otherwise call/return opcodes are illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 8,
  parameter int RS_DEPTH = 16
) (
  input  logic               clkout,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [DATA_W-1:0]  alu_val,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [4:0]         alu_flags,
  output logic               busy,
  output logic               halted,
  output logic [1:0]         err
);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  instr_t            ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, val_q, val_d, res_q, res_d;
  logic [3:0]        zcsp_q, zcsp_d;
  logic              carry_q, carry_d;
  logic              exec_cnt_q, exec_cnt_d;
  logic              rf_we;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [PC_W-1:0]   imm_pc, pc_inc, jmp_tgt;
  logic              cond_ok;
  logic              unused_flag_v;

  assign unused_flag_v = alu_flags[0];
  assign imm_pc  = ir_q.imm[PC_W-1:0];
  assign pc_inc  = pc_q + PC_W'(1);
  // Within the jump/call group, odd opcodes are pc-relative.
  assign jmp_tgt = ir_q.opcode[0] ? (pc_q + imm_pc) : imm_pc;

  always_comb begin
    case (ir_q.rs[1:0])
      2'd0:    cond_ok = zcsp_q[3];
      2'd1:    cond_ok = zcsp_q[2];
      2'd2:    cond_ok = zcsp_q[1];
      default: cond_ok = zcsp_q[0];
    endcase
  end

`ifdef ALU_SEQ_CALLSTACK_EN
  logic            rs_push, rs_pop, rs_full, rs_empty;
  logic [PC_W-1:0] rs_top;

  alu_seq_rstack #(
    .PC_W    (PC_W),
    .RS_DEPTH(RS_DEPTH)
  ) u_rstack (
    .clk_i  (clkout),
    .rst_i  (rst),
    .push_i (rs_push),
    .pop_i  (rs_pop),
    .data_i (pc_inc),
    .top_o  (rs_top),
    .full_o (rs_full),
    .empty_o(rs_empty)
  );
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    opc_d      = opc_q;
    a_d        = a_q;
    b_d        = b_q;
    val_d      = val_q;
    res_d      = res_q;
    zcsp_d     = zcsp_q;
    carry_d    = carry_q;
    exec_cnt_d = exec_cnt_q;
    rf_we      = 1'b0;
`ifdef ALU_SEQ_CALLSTACK_EN
    rs_push    = 1'b0;
    rs_pop     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!op_legal(ir_q.opcode)) begin
          state_d = ST_HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          opc_d      = ir_q.opcode;
          a_d        = regs_q[ir_q.rd];
          b_d        = regs_q[ir_q.rs];
          val_d      = DATA_W'($signed(ir_q.imm));
          exec_cnt_d = op_is_shift(ir_q.opcode);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_cnt_q) begin
          exec_cnt_d = 1'b0;
        end else begin
          res_d   = alu_result;
          zcsp_d  = alu_flags[4:1];
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (op_writes_rd(ir_q.opcode)) begin
          rf_we   = 1'b1;
          carry_d = zcsp_q[2];
        end
        case (ir_q.opcode)
          OP_JUD, OP_JUP: pc_d = jmp_tgt;
          OP_JCD, OP_JCP: if (cond_ok) pc_d = jmp_tgt;
`ifdef ALU_SEQ_CALLSTACK_EN
          OP_CUD, OP_CUP, OP_CCD, OP_CCP: begin
            if (cond_ok || ir_q.opcode == OP_CUD || ir_q.opcode == OP_CUP) begin
              if (rs_full) begin
                pc_d    = pc_q;
                state_d = ST_HALT;
                err_d   = ERR_OVERFLOW;
              end else begin
                rs_push = 1'b1;
                pc_d    = jmp_tgt;
              end
            end
          end
          OP_RTU, OP_RTC: begin
            if (cond_ok || ir_q.opcode == OP_RTU) begin
              if (rs_empty) begin
                pc_d    = pc_q;
                state_d = ST_HALT;
                err_d   = ERR_UNDERFLOW;
              end else begin
                rs_pop = 1'b1;
                pc_d   = rs_top;
              end
            end
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkout) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_q      <= ERR_NONE;
      ir_q       <= '0;
      pc_q       <= '0;
      opc_q      <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      val_q      <= '0;
      res_q      <= '0;
      zcsp_q     <= '0;
      carry_q    <= 1'b0;
      exec_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      opc_q      <= opc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      val_q      <= val_d;
      res_q      <= res_d;
      zcsp_q     <= zcsp_d;
      carry_q    <= carry_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  always_ff @(posedge clkout) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[ir_q.rd] <= res_q;
    end
  end

  // A fetch is withdrawn in the very cycle reset is asserted.
  assign imem_req   = (state_q == ST_FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign alu_opcode = opc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_val    = val_q;
  assign alu_cin    = carry_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted     = (state_q == ST_HALT);
  assign err        = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: behavioural instruction memory and ALU, fetch-address scoreboard.
// Call/return checks depend on whether ALU_SEQ_CALLSTACK_EN is defined.
module tb_alu_seq;

  localparam logic [7:0]  OP_ADD  = 8'd1;
  localparam logic [7:0]  OP_SRL  = 8'd20;
  localparam logic [7:0]  OP_JUP  = 8'd33;
  localparam logic [7:0]  OP_JCD  = 8'd34;
  localparam logic [7:0]  OP_CUD  = 8'd36;
  localparam logic [7:0]  OP_RTU  = 8'd40;
  localparam logic [7:0]  OP_MVR  = 8'd47;
  localparam logic [7:0]  OP_NOP  = 8'd53;
  localparam logic [31:0] ILLEGAL = 32'hFF00_0000;

  logic        clkout = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [7:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_val, alu_result;
  logic        alu_cin;
  logic [4:0]  alu_flags;
  logic        busy, halted;
  logic [1:0]  err;

  logic [31:0] mem [256];
  logic [4:0]  flags_drv = '0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];

  alu_seq dut (
    .clkout    (clkout),
    .rst       (rst),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_opcode(alu_opcode),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_val   (alu_val),
    .alu_cin   (alu_cin),
    .alu_result(alu_result),
    .alu_flags (alu_flags),
    .busy      (busy),
    .halted    (halted),
    .err       (err)
  );

  // clock / reset
  always #5 clkout = ~clkout;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // instruction memory: answers ack_delay cycles into a fetch
  always @(posedge clkout) begin
    #1;
    if (imem_req && wait_cnt == ack_delay) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
      wait_cnt  = 0;
    end else begin
      imem_ack  = 1'b0;
      imem_data = '0;
      if (imem_req) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  // reference ALU for the opcodes the programs use
  always_comb begin
    case (alu_opcode)
      OP_MVR:  alu_result = alu_val;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SRL:  alu_result = alu_a >> alu_b[4:0];
      default: alu_result = '0;
    endcase
  end
  assign alu_flags = flags_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted fetch must match the next expected address
  always @(negedge clkout) begin
    if (imem_req && imem_ack && exp_q.size() > 0) check("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_q.pop_front()});
  end

  // driver tasks
  function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clkout);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic blank_mem();
    for (int i = 0; i < 256; i++) mem[i] = ILLEGAL;
  endtask

  task automatic drain_check(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    tick(1);

    // reset state and a two-instruction program
    blank_mem();
    mem[0] = enc(OP_MVR, 4'd1, 4'd0, 16'd5);
    mem[1] = enc(OP_ADD, 4'd1, 4'd1, 16'd0);
    mem[2] = enc(OP_NOP, 4'd1, 4'd0, 16'd0);
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_req", imem_req, 0);
    check("rst_opcode", alu_opcode, 53);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_val", alu_val, 0);
    check("rst_cin", alu_cin, 0);
    flags_drv = 5'b01000;
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    pulse_start();
    check("run_busy", busy, 1);
    check("run_req", imem_req, 1);
    tick(2);
    check("mvr_opcode", alu_opcode, 47);
    check("mvr_val", alu_val, 5);
    check("mvr_a", alu_a, 0);
    tick(2);
    check("mvr_carry", alu_cin, 1);
    tick(2);
    check("add_opcode", alu_opcode, 1);
    check("add_a", alu_a, 5);
    check("add_b", alu_b, 5);
    tick(2);
    check("pc_after_8", imem_addr, 2);
    tick(2);
    check("r1_sum", alu_a, 10);
    tick(4);
    check("ill_halted", halted, 1);
    check("ill_err", err, 1);
    check("ill_busy", busy, 0);
    pulse_start();
    tick(3);
    check("halt_start_ignored", halted, 1);
    check("halt_no_fetch", imem_req, 0);
    do_reset();
    check("halt_rst_err", err, 0);
    check("halt_rst_halted", halted, 0);
    drain_check("prog_a_fetches");

    // slow memory, then reset in the middle of a fetch
    blank_mem();
    mem[0] = enc(OP_MVR, 4'd2, 4'd0, 16'hFFF9);
    mem[1] = enc(OP_NOP, 4'd2, 4'd0, 16'd0);
    ack_delay = 3;
    exp_q = '{8'd0, 8'd1};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("slow_req", imem_req, 1);
      check("slow_addr", imem_addr, 0);
      tick(1);
    end
    tick(1);
    check("slow_val_sext", alu_val, 32'hFFFF_FFF9);
    tick(2);
    check("slow_7cyc_req", imem_req, 1);
    check("slow_7cyc_addr", imem_addr, 1);
    tick(5);
    check("slow_r2", alu_a, 32'hFFFF_FFF9);
    tick(2);
    check("fetch2_req", imem_req, 1);
    rst = 1'b1;
    #1;
    check("rst_drops_req", imem_req, 0);
    tick(1);
    rst = 1'b0;
    check("rst_fetch_busy", busy, 0);
    ack_delay = 0;
    drain_check("prog_b_fetches");

    // conditional and relative jumps
    blank_mem();
    mem[8'h00] = enc(OP_JCD, 4'd0, 4'd0, 16'h0020);
    mem[8'h20] = enc(OP_JCD, 4'd0, 4'd0, 16'h0040);
    mem[8'h21] = enc(OP_JUP, 4'd0, 4'd0, 16'hFFFE);
    do_reset();
    flags_drv = 5'b10000;
    exp_q = '{8'h00, 8'h20, 8'h21, 8'h1F};
    pulse_start();
    tick(4);
    check("jcd_taken", imem_addr, 8'h20);
    flags_drv = 5'b00000;
    tick(4);
    check("jcd_not_taken", imem_addr, 8'h21);
    tick(4);
    check("jup_back", imem_addr, 8'h1F);
    tick(2);
    check("jmp_prog_err", err, 1);
    drain_check("prog_c_fetches");

    // call / return
    blank_mem();
    mem[0]     = enc(OP_NOP, 4'd0, 4'd0, 16'd0);
    mem[1]     = enc(OP_NOP, 4'd0, 4'd0, 16'd0);
    mem[2]     = enc(OP_NOP, 4'd0, 4'd0, 16'd0);
    mem[3]     = enc(OP_CUD, 4'd0, 4'd0, 16'h0010);
    mem[8'h10] = enc(OP_RTU, 4'd0, 4'd0, 16'd0);
    mem[4]     = enc(OP_CUD, 4'd0, 4'd0, 16'h0030);
    mem[8'h30] = enc(OP_CUD, 4'd0, 4'd0, 16'h0030);
    do_reset();
`ifdef ALU_SEQ_CALLSTACK_EN
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'h10, 8'd4};
    pulse_start();
    tick(16);
    check("cud_target", imem_addr, 8'h10);
    tick(4);
    check("rtu_return", imem_addr, 8'd4);
    n = 0;
    while (!halted && n < 200) begin
      tick(1);
      n++;
    end
    check("ovf_cycles", n, 68);
    check("ovf_halted", halted, 1);
    check("ovf_err", err, 2);
    drain_check("prog_d_fetches");
    blank_mem();
    mem[0] = enc(OP_RTU, 4'd0, 4'd0, 16'd0);
    do_reset();
    pulse_start();
    tick(4);
    check("unf_halted", halted, 1);
    check("unf_err", err, 3);
`else
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    pulse_start();
    tick(14);
    check("cud_illegal_halted", halted, 1);
    check("cud_illegal_err", err, 1);
    drain_check("prog_d_fetches");
`endif

    // two-cycle shift, then reset during its second execute cycle
    blank_mem();
    mem[0] = enc(OP_MVR, 4'd3, 4'd0, 16'd9);
    mem[1] = enc(OP_MVR, 4'd4, 4'd0, 16'd1);
    mem[2] = enc(OP_SRL, 4'd3, 4'd4, 16'd0);
    mem[3] = enc(OP_NOP, 4'd3, 4'd0, 16'd0);
    do_reset();
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    pulse_start();
    tick(10);
    check("srl_opcode", alu_opcode, 20);
    tick(2);
    check("srl_no_early_fetch", imem_req, 0);
    tick(1);
    check("srl_next_addr", imem_addr, 3);
    tick(2);
    check("srl_result", alu_a, 4);
    tick(4);
    drain_check("prog_f_fetches");
    do_reset();
    exp_q = '{8'd0, 8'd1, 8'd2};
    pulse_start();
    tick(11);
    check("srl2_exec2_opcode", alu_opcode, 20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("exec_rst_busy", busy, 0);
    check("exec_rst_halted", halted, 0);
    check("exec_rst_req", imem_req, 0);
    check("exec_rst_opcode", alu_opcode, 53);
    drain_check("prog_g_fetches");
    mem[0] = enc(OP_NOP, 4'd3, 4'd0, 16'd0);
    exp_q = '{8'd0};
    pulse_start();
    tick(2);
    check("r3_after_rst", alu_a, 0);
    do_reset();
    drain_check("prog_h_fetches");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
